// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: round-robin fade sequencer driving the duty inputs of NUM_CH PWM units.
// Define PWM_FADE_IRQ_EN to add the sticky done status register and the irq/irq_clr ports.
module pwm_fade_ctrl #(
    parameter int NUM_CH = 4,
    parameter int VAL_W  = 8,
    parameter int STEP_W = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    pwm_clk,
    input  logic                    pwm_reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [CH_W-1:0]         cmd_ch,
    input  logic [VAL_W-1:0]        cmd_target,
    input  logic [STEP_W-1:0]       cmd_step,
    input  logic [NUM_CH-1:0]       pwm_period,
    output logic [NUM_CH*VAL_W-1:0] pwm_value,
    output logic [NUM_CH-1:0]       busy,
    output logic                    done,
    output logic [CH_W-1:0]         done_ch
`ifdef PWM_FADE_IRQ_EN
    ,
    output logic                    irq,
    input  logic [NUM_CH-1:0]       irq_clr
`endif
);

    localparam int   EW      = VAL_W + 1;
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RAMP = 1'b1;

    logic [VAL_W-1:0]  val [NUM_CH];
    logic [VAL_W-1:0]  tgt [NUM_CH];
    logic [STEP_W-1:0] stp [NUM_CH];
    logic [NUM_CH-1:0] state;
    logic [NUM_CH-1:0] period_q;
    logic [NUM_CH-1:0] pend;
    logic [CH_W-1:0]   ptr;
    logic              ready_en;
    logic              hold_v;
    logic [CH_W-1:0]   hold_ch;

    logic [NUM_CH-1:0] cmd_sel;
    logic [NUM_CH-1:0] svc_sel;
    logic [VAL_W-1:0]  cmd_cur;
    logic              cmd_imm;
    logic [VAL_W-1:0]  s_val;
    logic [VAL_W-1:0]  s_tgt;
    logic [STEP_W-1:0] s_stp;
    logic              s_pend;
    logic              s_ramp;
    logic              s_cmd;
    logic [EW-1:0]     sum;
    logic [EW-1:0]     dif;
    logic [VAL_W-1:0]  nxt;
    logic              svc_go;
    logic              ramp_done;
    logic              emit_v;
    logic [CH_W-1:0]   emit_ch;
    logic              hold_n;

    assign cmd_ready = ready_en & ~hold_v;

    // Out-of-range cmd_ch matches no channel, so such a command is consumed with no effect.
    always_comb begin
        cmd_sel = '0;
        svc_sel = '0;
        cmd_cur = '0;
        s_val   = '0;
        s_tgt   = '0;
        s_stp   = '0;
        s_pend  = 1'b0;
        s_ramp  = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cmd_ch == CH_W'(i)) begin
                cmd_sel[i] = cmd_valid & cmd_ready;
                cmd_cur    = val[i];
            end
            if (ptr == CH_W'(i)) begin
                svc_sel[i] = 1'b1;
                s_val      = val[i];
                s_tgt      = tgt[i];
                s_stp      = stp[i];
                s_pend     = pend[i];
                s_ramp     = (state[i] == ST_RAMP);
            end
        end
        s_cmd   = |(cmd_sel & svc_sel);
        cmd_imm = (|cmd_sel) && ((cmd_step == '0) || (cmd_target == cmd_cur));
    end

    always_comb begin
        sum = EW'(s_val) + EW'(s_stp);
        dif = EW'(s_val) - EW'(s_stp);
        if (s_tgt > s_val)
            nxt = (sum > EW'(s_tgt)) ? s_tgt : sum[VAL_W-1:0];
        else
            nxt = (dif[VAL_W] || (dif[VAL_W-1:0] < s_tgt)) ? s_tgt : dif[VAL_W-1:0];
        svc_go    = s_pend & s_ramp & ~s_cmd;
        ramp_done = svc_go && (nxt == s_tgt);
    end

    // Held completion goes first; cmd_ready is low then, so no immediate done can compete.
    always_comb begin
        emit_v  = hold_v | cmd_imm | ramp_done;
        emit_ch = hold_v ? hold_ch : (cmd_imm ? cmd_ch : ptr);
        hold_n  = ramp_done & (hold_v | cmd_imm);
    end

    always_ff @(posedge pwm_clk or posedge pwm_reset) begin
        if (pwm_reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                val[i] <= '0;
                tgt[i] <= '0;
                stp[i] <= '0;
            end
            state    <= {NUM_CH{ST_IDLE}};
            period_q <= '0;
            pend     <= '0;
            ptr      <= '0;
            ready_en <= 1'b0;
            hold_v   <= 1'b0;
            hold_ch  <= '0;
            done     <= 1'b0;
            done_ch  <= '0;
        end else begin
            ready_en <= 1'b1;
            period_q <= pwm_period;
            pend     <= (pend & ~svc_sel) | (pwm_period & ~period_q);
            ptr      <= (ptr == CH_W'(NUM_CH - 1)) ? '0 : ptr + 1'b1;
            hold_v   <= hold_n;
            if (hold_n)
                hold_ch <= ptr;
            done    <= emit_v;
            done_ch <= emit_ch;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (cmd_sel[i]) begin
                    tgt[i] <= cmd_target;
                    stp[i] <= cmd_step;
                    if (cmd_imm) begin
                        val[i]   <= cmd_target;
                        state[i] <= ST_IDLE;
                    end else begin
                        state[i] <= ST_RAMP;
                    end
                end else if (svc_go && svc_sel[i]) begin
                    val[i] <= nxt;
                    if (ramp_done)
                        state[i] <= ST_IDLE;
                end
            end
        end
    end

    always_comb begin
        pwm_value = '0;
        busy      = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pwm_value[i*VAL_W +: VAL_W] = val[i];
            busy[i]                     = (state[i] == ST_RAMP);
        end
    end

`ifdef PWM_FADE_IRQ_EN
    logic [NUM_CH-1:0] irq_status;
    logic [NUM_CH-1:0] irq_set;

    always_comb begin
        irq_set = '0;
        for (int unsigned i = 0; i < NUM_CH; i++)
            if (emit_v && (emit_ch == CH_W'(i)))
                irq_set[i] = 1'b1;
    end

    always_ff @(posedge pwm_clk or posedge pwm_reset) begin
        if (pwm_reset)
            irq_status <= '0;
        else
            irq_status <= (irq_status & ~irq_clr) | irq_set;
    end

    assign irq = |irq_status;
`endif

endmodule
